// File: rtl/rename_regfile_mp_if.sv
// rtl/rename_regfile_mp_if.sv - decode/dispatch/commit bus of the rename register file
// Parameters must match the rename_regfile_mp instance the interface is bound to.
interface rename_regfile_mp_if #(
   parameter int REG_COUNT  = 32,
   parameter int DATA_W     = 32,
   parameter int ROB_TAG_W  = 4,
   parameter int READ_PORTS = 2
) ();
   localparam int IDX_W = $clog2(REG_COUNT);
   localparam int CNT_W = $clog2(REG_COUNT + 1);

   logic [READ_PORTS*IDX_W-1:0]     in_rd_idx;
   logic [READ_PORTS*DATA_W-1:0]    out_rd_value;
   logic [READ_PORTS*ROB_TAG_W-1:0] out_rd_tag;
   logic [READ_PORTS-1:0]           out_rd_busy;
   logic                            in_dispatch_valid;
   logic [IDX_W-1:0]                in_dispatch_reg;
   logic [ROB_TAG_W-1:0]            in_dispatch_rob;
   logic                            in_commit_valid;
   logic [IDX_W-1:0]                in_commit_reg;
   logic [ROB_TAG_W-1:0]            in_commit_rob;
   logic [DATA_W-1:0]               in_commit_value;
   logic                            in_flush;
   logic [CNT_W-1:0]                out_busy_count;

   modport slave (
      input  in_rd_idx, in_dispatch_valid, in_dispatch_reg, in_dispatch_rob,
      input  in_commit_valid, in_commit_reg, in_commit_rob, in_commit_value, in_flush,
      output out_rd_value, out_rd_tag, out_rd_busy, out_busy_count
   );

   modport master (
      output in_rd_idx, in_dispatch_valid, in_dispatch_reg, in_dispatch_rob,
      output in_commit_valid, in_commit_reg, in_commit_rob, in_commit_value, in_flush,
      input  out_rd_value, out_rd_tag, out_rd_busy, out_busy_count
   );
endinterface

// File: rtl/rename_regfile_mp.sv
// rtl/rename_regfile_mp.sv - architectural register file with rename status and busy count
// Optional same-cycle commit-to-read bypass: RENAME_COMMIT_BYPASS_EN.
module rename_regfile_mp #(
   parameter int REG_COUNT  = 32,
   parameter int DATA_W     = 32,
   parameter int ROB_TAG_W  = 4,
   parameter int READ_PORTS = 2
) (
   input logic               clk,
   input logic               rst,
   input logic               rdy,
   rename_regfile_mp_if.slave bus
);
   localparam int IDX_W = $clog2(REG_COUNT);
   localparam int CNT_W = $clog2(REG_COUNT + 1);

   logic [DATA_W-1:0]               r_value [REG_COUNT];
   logic [ROB_TAG_W-1:0]            r_tag   [REG_COUNT];
   logic [REG_COUNT-1:0]            r_busy;
   logic [CNT_W-1:0]                r_busy_count;

   logic [REG_COUNT-1:0]            w_busy_nxt;
   logic [CNT_W-1:0]                w_cnt_nxt;
   logic                            w_commit_en;
   logic                            w_commit_match;
   logic                            w_dispatch_en;
   logic [IDX_W-1:0]                w_idx;
   logic [READ_PORTS*DATA_W-1:0]    w_rd_value;
   logic [READ_PORTS*ROB_TAG_W-1:0] w_rd_tag;
   logic [READ_PORTS-1:0]           w_rd_busy;

   assign w_commit_en    = bus.in_commit_valid && (bus.in_commit_reg != '0);
   // A commit only releases the register if no younger rename has taken ownership.
   assign w_commit_match = w_commit_en && (r_tag[bus.in_commit_reg] == bus.in_commit_rob);
   assign w_dispatch_en  = bus.in_dispatch_valid && (bus.in_dispatch_reg != '0) && !bus.in_flush;

   always_comb begin
      w_busy_nxt = r_busy;
      if (w_commit_match) w_busy_nxt[bus.in_commit_reg] = 1'b0;
      if (bus.in_flush) w_busy_nxt = '0;
      else if (w_dispatch_en) w_busy_nxt[bus.in_dispatch_reg] = 1'b1;
      w_cnt_nxt = '0;
      for (int i = 0; i < REG_COUNT; i++) w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[i]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy       <= '0;
         r_busy_count <= '0;
         for (int i = 0; i < REG_COUNT; i++) begin
            r_value[i] <= '0;
            r_tag[i]   <= '0;
         end
      end else if (rdy) begin
         r_busy       <= w_busy_nxt;
         r_busy_count <= w_cnt_nxt;
         if (w_commit_en) r_value[bus.in_commit_reg] <= bus.in_commit_value;
         if (bus.in_flush) begin
            for (int i = 0; i < REG_COUNT; i++) r_tag[i] <= '0;
         end else if (w_dispatch_en) begin
            r_tag[bus.in_dispatch_reg] <= bus.in_dispatch_rob;
         end
      end
   end

   // Sources are read before the same-cycle dispatch, so dispatch never feeds the read ports.
   always_comb begin
      w_rd_value = '0;
      w_rd_tag   = '0;
      w_rd_busy  = '0;
      w_idx      = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         w_idx = bus.in_rd_idx[p*IDX_W +: IDX_W];
         if (w_idx != '0) begin
            w_rd_value[p*DATA_W +: DATA_W]       = r_value[w_idx];
            w_rd_tag[p*ROB_TAG_W +: ROB_TAG_W]   = r_tag[w_idx];
            w_rd_busy[p]                         = r_busy[w_idx];
`ifdef RENAME_COMMIT_BYPASS_EN
            if (w_commit_en && (bus.in_commit_reg == w_idx) &&
                (bus.in_commit_rob == r_tag[w_idx])) begin
               w_rd_value[p*DATA_W +: DATA_W] = bus.in_commit_value;
               w_rd_busy[p]                   = 1'b0;
            end
`endif
         end
      end
   end

   assign bus.out_rd_value   = w_rd_value;
   assign bus.out_rd_tag     = w_rd_tag;
   assign bus.out_rd_busy    = w_rd_busy;
   assign bus.out_busy_count = r_busy_count;
endmodule

// File: tb/tb_rename_regfile_mp.sv
// tb/tb_rename_regfile_mp.sv - self-checking bench for rename_regfile_mp
// Reference model honours RENAME_COMMIT_BYPASS_EN when the build defines it.
module tb_rename_regfile_mp;
   localparam int NR = 32;
   localparam int DW = 32;
   localparam int TW = 4;
   localparam int RP = 2;
   localparam int IW = 5;
   localparam int CW = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rdy = 1'b1;

   rename_regfile_mp_if #(.REG_COUNT(NR), .DATA_W(DW), .ROB_TAG_W(TW), .READ_PORTS(RP)) bus ();

   rename_regfile_mp #(.REG_COUNT(NR), .DATA_W(DW), .ROB_TAG_W(TW), .READ_PORTS(RP)) dut (
      .clk(clk),
      .rst(rst),
      .rdy(rdy),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] m_val  [NR];
   logic [TW-1:0] m_tag  [NR];
   logic          m_busy [NR];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NR; i++) begin
         m_val[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   task automatic set_in(input logic dv, input int dr, input int drob,
                         input logic cv, input int cr, input int crob, input logic [DW-1:0] cval,
                         input logic fl);
      bus.in_dispatch_valid = dv;
      bus.in_dispatch_reg   = IW'(dr);
      bus.in_dispatch_rob   = TW'(drob);
      bus.in_commit_valid   = cv;
      bus.in_commit_reg     = IW'(cr);
      bus.in_commit_rob     = TW'(crob);
      bus.in_commit_value   = cval;
      bus.in_flush          = fl;
   endtask

   task automatic idle();
      set_in(1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b0);
   endtask

   // One clock edge: model applies the rules from its own pre-edge state, then inputs return idle.
   task automatic tick();
      int cr, dr;
      @(posedge clk);
      cr = int'(bus.in_commit_reg);
      dr = int'(bus.in_dispatch_reg);
      if (rdy && rst) begin
         if (bus.in_commit_valid && cr != 0) begin
            m_val[cr] = bus.in_commit_value;
            if (m_tag[cr] == bus.in_commit_rob) m_busy[cr] = 1'b0;
         end
         if (bus.in_flush) begin
            for (int i = 0; i < NR; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
         end else if (bus.in_dispatch_valid && dr != 0) begin
            m_busy[dr] = 1'b1;
            m_tag[dr]  = bus.in_dispatch_rob;
         end
      end
      @(negedge clk);
      idle();
   endtask

   task automatic chk_read(input string tag, input int p, input int idx);
      logic [DW-1:0] ev;
      logic [TW-1:0] et;
      logic          eb;
      bus.in_rd_idx[p*IW +: IW] = IW'(idx);
      #1;
      ev = (idx == 0) ? '0 : m_val[idx];
      et = (idx == 0) ? '0 : m_tag[idx];
      eb = (idx == 0) ? 1'b0 : m_busy[idx];
`ifdef RENAME_COMMIT_BYPASS_EN
      if (idx != 0 && bus.in_commit_valid && int'(bus.in_commit_reg) == idx &&
          bus.in_commit_rob == m_tag[idx]) begin
         ev = bus.in_commit_value;
         eb = 1'b0;
      end
`endif
      chk({tag, "_value"}, 64'(bus.out_rd_value[p*DW +: DW]), 64'(ev));
      chk({tag, "_tag"},   64'(bus.out_rd_tag[p*TW +: TW]),   64'(et));
      chk({tag, "_busy"},  64'(bus.out_rd_busy[p]),           64'(eb));
   endtask

   task automatic chk_count(input string tag);
      chk(tag, 64'(bus.out_busy_count), 64'(model_count()));
   endtask

   initial begin
      logic [DW-1:0] rv;
      int r, t;
      bus.in_rd_idx = '0;
      idle();
      model_clear();

      // 1. reset
      #12;
      for (int p = 0; p < RP; p++) begin
         chk_read("rst_r0", p, 0);
         chk_read("rst_r5", p, 5);
         chk_read("rst_r31", p, 31);
      end
      chk("rst_count", 64'(bus.out_busy_count), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 2. rename and commit
      set_in(1'b1, 5, 3, 1'b0, 0, 0, '0, 1'b0); tick();
      chk_read("ren_r5", 0, 5);
      chk("ren_count", 64'(bus.out_busy_count), 64'd1);
      chk("ren_tag3", 64'(bus.out_rd_tag[0 +: TW]), 64'd3);
      set_in(1'b0, 0, 0, 1'b1, 5, 3, 32'hDEADBEEF, 1'b0); tick();
      chk_read("cmt_r5", 1, 5);
      chk("cmt_val", 64'(bus.out_rd_value[DW +: DW]), 64'hDEADBEEF);
      chk("cmt_count", 64'(bus.out_busy_count), 64'd0);

      // 3. stale commit
      set_in(1'b1, 7, 2, 1'b0, 0, 0, '0, 1'b0); tick();
      set_in(1'b1, 7, 6, 1'b0, 0, 0, '0, 1'b0); tick();
      set_in(1'b0, 0, 0, 1'b1, 7, 2, 32'h11, 1'b0); tick();
      chk_read("stale_r7", 0, 7);
      chk("stale_busy", 64'(bus.out_rd_busy[0]), 64'd1);
      chk("stale_tag", 64'(bus.out_rd_tag[0 +: TW]), 64'd6);
      set_in(1'b0, 0, 0, 1'b1, 7, 6, 32'h22, 1'b0); tick();
      chk_read("own_r7", 0, 7);
      chk("own_val", 64'(bus.out_rd_value[0 +: DW]), 64'h22);

      // 4. same-cycle collision
      set_in(1'b1, 9, 4, 1'b0, 0, 0, '0, 1'b0); tick();
      set_in(1'b1, 9, 8, 1'b1, 9, 4, 32'h55, 1'b0); tick();
      chk_read("coll_r9", 1, 9);
      chk("coll_tag", 64'(bus.out_rd_tag[TW +: TW]), 64'd8);
      chk("coll_val", 64'(bus.out_rd_value[DW +: DW]), 64'h55);

      // 5. flush
      set_in(1'b1, 1, 1, 1'b0, 0, 0, '0, 1'b0); tick();
      set_in(1'b1, 2, 2, 1'b0, 0, 0, '0, 1'b0); tick();
      set_in(1'b1, 3, 5, 1'b0, 0, 0, '0, 1'b0); tick();
      chk_count("pre_flush_count");
      set_in(1'b1, 4, 1, 1'b1, 2, 7, 32'h99, 1'b1); tick();
      for (int i = 1; i <= 4; i++) chk_read($sformatf("flush_r%0d", i), 0, i);
      chk("flush_r2_val", 64'(dut.r_value[2]), 64'h99);
      chk("flush_count", 64'(bus.out_busy_count), 64'd0);
      set_in(1'b1, 0, 5, 1'b1, 0, 5, 32'hABCD, 1'b0); tick();
      chk_read("r0_write", 0, 0);
      chk_count("r0_count");

      // 6. rdy hold and bypass
      rdy = 1'b0;
      set_in(1'b1, 10, 3, 1'b1, 9, 8, 32'h1234, 1'b0); tick();
      chk_read("hold_r10", 0, 10);
      chk_read("hold_r9", 1, 9);
      chk_count("hold_count");
      rdy = 1'b1;
      set_in(1'b1, 5, 9, 1'b0, 0, 0, '0, 1'b0); tick();
      set_in(1'b0, 0, 0, 1'b1, 5, 9, 32'h77, 1'b0);
      chk_read("byp_r5", 1, 5);
`ifdef RENAME_COMMIT_BYPASS_EN
      chk("byp_val", 64'(bus.out_rd_value[DW +: DW]), 64'h77);
      chk("byp_busy", 64'(bus.out_rd_busy[1]), 64'd0);
`else
      chk("byp_val", 64'(bus.out_rd_value[DW +: DW]), 64'hDEADBEEF);
      chk("byp_busy", 64'(bus.out_rd_busy[1]), 64'd1);
`endif
      tick();
      chk_read("post_byp_r5", 0, 5);

      // randomized traffic on a narrow register range to force collisions
      for (int n = 0; n < 300; n++) begin
         rdy = ($urandom_range(0, 9) != 0);
         r = $urandom_range(0, 15);
         t = (m_tag[r] != 0 && $urandom_range(0, 2) != 0) ? int'(m_tag[r]) : $urandom_range(0, 15);
         rv = $urandom;
         set_in($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(1, 15),
                $urandom_range(0, 1) == 1, r, t, rv, $urandom_range(0, 19) == 0);
         chk_read("rnd_p0", 0, $urandom_range(0, 15));
         chk_read("rnd_p1", 1, (n % 2 == 0) ? r : $urandom_range(0, 15));
         tick();
         chk_count("rnd_count");
      end
      rdy = 1'b1;

      // reset mid-operation drops all renames at once
      set_in(1'b1, 11, 4, 1'b0, 0, 0, '0, 1'b0); tick();
      rst = 1'b0;
      model_clear();
      #1;
      chk_read("mid_rst_r11", 0, 11);
      chk("mid_rst_count", 64'(bus.out_busy_count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rename_regfile_mp.md
Name: rename_regfile_mp

Overview:
- Parametrised architectural register file with rename status, for the Tomasulo core. Generalised successor of the single-pair rename register file.
- Holds a committed value, a busy flag and an owning ROB tag for each register.
- Gives decode READ_PORTS combinational source lookups. Takes one rename update per cycle from dispatch and one commit per cycle from the ROB.
- Clears all rename state on a misbranch flush, and keeps a registered count of renamed (busy) registers for dispatch-side throttling.

Parameters:
- REG_COUNT, 32, number of architectural registers (power of two, >=2); register 0 is hardwired zero.
- DATA_W, 32, register value width.
- ROB_TAG_W, 4, ROB tag width; tag 0 is the "no owner" value.
- READ_PORTS, 2, number of independent decode read ports (1..4).
- Derived localparam IDX_W = $clog2(REG_COUNT); CNT_W = $clog2(REG_COUNT+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when 0, all state holds.
- in_rd_idx  in  READ_PORTS*IDX_W  packed read indices; port p uses bits [p*IDX_W +: IDX_W].
- out_rd_value  out  READ_PORTS*DATA_W  packed register values.
- out_rd_tag  out  READ_PORTS*ROB_TAG_W  packed owning ROB tags.
- out_rd_busy  out  READ_PORTS  per-port busy flag.
- in_dispatch_valid  in  1  rename update request.
- in_dispatch_reg  in  IDX_W  destination register being renamed.
- in_dispatch_rob  in  ROB_TAG_W  new owning ROB tag.
- in_commit_valid  in  1  ROB commit request.
- in_commit_reg  in  IDX_W  committed destination register.
- in_commit_rob  in  ROB_TAG_W  tag of the committing entry.
- in_commit_value  in  DATA_W  committed value.
- in_flush  in  1  misbranch flush.
- out_busy_count  out  CNT_W  number of registers currently busy (registered).

Behaviour:
- Reset (rst=0, asynchronous): all values=0, busy=0, tags=0, out_busy_count=0. Outputs reflect this immediately after reset asserts. Reset mid-operation discards all pending renames.
- Read ports are purely combinational from the current state, subject to the bypass in Optional Feature. Reading register 0 always returns value 0, tag 0, busy 0.
- All updates below happen at posedge clk with rst=1 and rdy=1 only. With rdy=0, state and out_busy_count hold.
- Register 0 ignores every write, rename and commit.
- Commit, when in_commit_valid=1 and reg!=0:
  - values[reg] <= in_commit_value, unconditionally.
  - busy[reg] <= 0 only if tags[reg]==in_commit_rob, i.e. no younger rename is pending. tags[reg] is left unchanged.
- Dispatch, when in_dispatch_valid=1 and reg!=0 and in_flush=0: busy[reg] <= 1, tags[reg] <= in_dispatch_rob.
- Commit and dispatch to the same register in the same cycle: dispatch wins for busy and tag (busy=1, new tag). The commit value is still written.
- Flush (in_flush=1): every busy <= 0 and every tag <= 0. Any dispatch in the same cycle is dropped. A commit in the same cycle still writes its value, because committed instructions are older than the misbranch.
- out_busy_count: registered; equals the popcount of the busy vector after each edge. It is computed from the next-state busy vector, so it never lags the state by a cycle. It is 0 the cycle after a flush.
- No handshake back-pressure. Upstream guarantees that at most one dispatch and one commit arrive per cycle.

Optional Feature:
- Macro: RENAME_COMMIT_BYPASS_EN.
- Defined: for each read port p, if in_commit_valid=1, in_commit_reg==in_rd_idx[p]!=0 and in_commit_rob==tags[idx], then in the same cycle:
  - out_rd_value[p] = in_commit_value;
  - out_rd_busy[p] = 0;
  - out_rd_tag[p] = stored tag.
  - This saves decode a one-cycle wait on the result.
- Not defined: read ports show stored state only, and the committed value is visible from the next cycle.
- Dispatch in the same cycle never affects read outputs in either build. Sources are read before the instruction's own rename.

Test Plan:
1. Reset: hold rst=0, then release; read regs 0, 5 and 31 on all ports -> value 0, tag 0, busy 0; out_busy_count=0.
2. Rename and commit: dispatch reg 5 to ROB 3; next cycle read 5 -> busy 1, tag 3, count 1. Commit reg 5, ROB 3, value 0xDEADBEEF; next cycle -> value 0xDEADBEEF, busy 0, count 0.
3. Stale commit: dispatch r7 to ROB 2, then r7 to ROB 6; commit r7, ROB 2, value 0x11 -> value 0x11, busy stays 1, tag 6. Commit r7, ROB 6, value 0x22 -> busy 0, value 0x22.
4. Same-cycle collision: r9 has tag 4; commit r9, ROB 4, value 0x55 and dispatch r9 to ROB 8 in one cycle -> value 0x55, busy 1, tag 8.
5. Flush: rename r1, r2 and r3; assert in_flush together with dispatch r4 to ROB 1 and commit r2 with value 0x99 -> all busy 0, tags 0, r2=0x99, r4 not renamed, count 0. Any dispatch to reg 0 -> no change.
6. rdy and bypass: with rdy=0, any dispatch or commit -> state holds. With RENAME_COMMIT_BYPASS_EN, commit r5 with matching tag and value 0x77 while port 1 reads r5 -> same-cycle value 0x77, busy 0. Without the macro -> old value, busy 1.
